alu_result_skid: RTL and testbench
==================================

Name: alu_result_skid

Overview:
- Downstream stage of the ALU add/subtract datapath.
- Captures the combinational result and overflow flag each cycle that a valid op is issued, and holds them with a valid/ready handshake toward register-file writeback.
- Holds up to two entries (main register plus skid register). When writeback stalls, this lets the ALU keep issuing one more op without dropping a result.
- Also keeps a sticky overflow flag and a saturating overflow counter for the status/CSR logic.

Parameters:
- DATA_W, 32, result width.
- TAG_W, 5, destination register index width.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- soc_clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  ALU presents a result this cycle.
- in_ready  out  1  stage can accept; transfer occurs when in_valid & in_ready.
- in_result  in  DATA_W  ALU add/sub output.
- in_overflow  in  1  ALU signed-overflow flag.
- in_rd  in  TAG_W  destination register index.
- out_valid  out  1  entry available for writeback.
- out_ready  in  1  writeback accepts; transfer occurs when out_valid & out_ready.
- out_result  out  DATA_W  result of the oldest entry.
- out_overflow  out  1  overflow flag of the oldest entry.
- out_rd  out  TAG_W  destination of the oldest entry.
- out_we  out  1  out_valid & (out_rd != 0); x0 is never written.
- ovf_sticky  out  1  set by any accepted overflowing result.
- ovf_sticky_clr  in  1  synchronous clear of ovf_sticky.
- ovf_count  out  CNT_W  saturating count of accepted overflowing results.

Behaviour:
- Reset (reset low, asynchronous): state EMPTY; out_valid=0; in_ready=1; out_result=0; out_overflow=0; out_rd=0; skid register=0; ovf_sticky=0; ovf_count=0.
- in_ready is a registered output equal to (state != FULL). It never depends combinationally on out_ready.
- Output fields always come from the main register. The skid register is never visible at the outputs.
- Latency: an accepted input appears on the outputs the next cycle when the stage is EMPTY, or when it is in ONE with a same-cycle pop. There is no combinational path from input to output.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- States:
  - EMPTY: push -> ONE (main <= input).
  - ONE, no push, no pop: stay in ONE.
  - ONE, push only: FULL (skid <= input).
  - ONE, pop only: EMPTY.
  - ONE, push and pop: stay in ONE (main <= input).
  - FULL, pop: ONE (main <= skid). A push is impossible while FULL because in_ready=0.
  - FULL, no pop: stay in FULL; all fields are held.
- Ordering is strictly FIFO; no entry is ever dropped or duplicated.
- flush: next state EMPTY and in_ready=1.
  - flush wins over a simultaneous push; the pushed entry is discarded.
  - A simultaneous pop still completes this cycle; the writeback side sees the current outputs.
  - flush does not affect ovf_sticky or ovf_count.
- Overflow bookkeeping on each push with in_overflow=1, including a push discarded by flush:
  - ovf_sticky is set.
  - ovf_count increments, saturating at 2^CNT_W-1; it never wraps.
- ovf_sticky_clr and an overflowing push in the same cycle: the set wins and ovf_sticky stays 1.
- ovf_count clears only on reset.
- Fields of an invalid entry hold their last value; out_valid and out_we stay 0.
- Reset asserted mid-transfer: all entries are lost immediately, with no partial state.

Decomposition:
- Shared ALU package:
  - state enum typedef (EMPTY, ONE, FULL) as 2-bit logic;
  - a packed struct alu_res_t {result, overflow, rd} used for both the main and skid registers;
  - constant REG_ZERO = 0.
- One sub-module is natural: ovf_counter (saturating counter with increment enable, CNT_W parameter).
- The state machine and the two data registers stay in the top module.

Test Plan:
- Reset then single op: in_valid=1, in_result=0x00000005, in_rd=3, out_ready=1.
  - Next cycle out_valid=1, out_result=5, out_we=1.
  - The following cycle out_valid=0.
- Back-to-back with stall: push A=0x11 and B=0x22 on consecutive cycles with out_ready=0.
  - in_ready drops to 0 after B.
  - Raise out_ready: outputs A then B on consecutive cycles.
  - in_ready returns to 1 one cycle after the first pop.
- Streaming: in_valid=1 and out_ready=1 continuously for 16 values 0..15.
  - Outputs 0..15 in order, one per cycle after the 1-cycle latency.
  - State never reaches FULL.
- x0 suppression: push in_rd=0, in_result=0xFFFFFFFF -> out_valid=1, out_we=0.
- Overflow: push 0x7FFFFFFF+1 with in_overflow=1 -> ovf_sticky=1 and ovf_count=1.
  - Then ovf_sticky_clr asserted together with another overflowing push -> ovf_sticky stays 1, ovf_count=2.
  - Saturation: 300 overflowing pushes -> ovf_count stays at 255.
- Flush and reset in FULL state:
  - flush together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed data never appears.
  - Separately, assert reset mid-stall asynchronously -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_result_skid_pkg.sv
// rtl/alu_result_skid_pkg.sv - shared types and constants for the ALU result skid stage
package alu_result_skid_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_TAG_W  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  overflow;
    logic [ALU_TAG_W-1:0]  rd;
  } alu_res_t;

  localparam logic [ALU_TAG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/alu_result_skid_ovf_counter.sv
// rtl/alu_result_skid_ovf_counter.sv - saturating overflow event counter
module ovf_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_skid.sv
// rtl/alu_result_skid.sv - two-entry skid buffer between ALU result and writeback
module alu_result_skid
  import alu_result_skid_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int TAG_W  = ALU_TAG_W,
  parameter int CNT_W  = 8
) (
  input  logic              soc_clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_overflow,
  input  logic [TAG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_overflow,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_we,
  output logic              ovf_sticky,
  input  logic              ovf_sticky_clr,
  output logic [CNT_W-1:0]  ovf_count
);

  state_e   state_q, state_d;
  alu_res_t main_q, skid_q, in_ent;
  logic     push, pop, ovf_inc;

  assign in_ent  = '{result: in_result, overflow: in_overflow, rd: in_rd};
  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  // Flushed pushes still count as overflow events.
  assign ovf_inc = push & in_overflow;

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // in_ready is a pure function of the state register, so it never sees out_ready.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
  end

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state_q)
        EMPTY: if (push) main_q <= in_ent;
        ONE: begin
          if (push && pop) main_q <= in_ent;
          else if (push)   skid_q <= in_ent;
        end
        FULL:    if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_result   = main_q.result;
  assign out_overflow = main_q.overflow;
  assign out_rd       = main_q.rd;
  assign out_we       = out_valid & (main_q.rd != REG_ZERO);

  // A same-cycle overflow wins over the clear.
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      ovf_sticky <= 1'b0;
    end else if (ovf_inc) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_sticky_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  ovf_counter #(.CNT_W(CNT_W)) u_ovf_counter (
    .clk   (soc_clk),
    .rst_n (reset),
    .inc   (ovf_inc),
    .count (ovf_count)
  );

endmodule

// File: tb/tb_alu_result_skid.sv
// tb/tb_alu_result_skid.sv - self-checking bench for alu_result_skid
module tb_alu_result_skid;

  logic        clk, rst_n, flush, in_valid, in_ready, in_overflow;
  logic [31:0] in_result, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_overflow, out_we;
  logic        ovf_sticky, ovf_sticky_clr;
  logic [7:0]  ovf_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  typedef struct {
    logic [31:0] r;
    logic        o;
    logic [4:0]  rd;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t held;
  bit     m_sticky;
  int     m_count;

  alu_result_skid dut (
    .soc_clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_overflow(in_overflow), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_rd(out_rd), .out_we(out_we),
    .ovf_sticky(ovf_sticky), .ovf_sticky_clr(ovf_sticky_clr), .ovf_count(ovf_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus event bookkeeping.
  initial begin
    held = '{r: 0, o: 0, rd: 0};
    m_sticky = 0;
    m_count = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        held = '{r: 0, o: 0, rd: 0};
        m_sticky = 0;
        m_count = 0;
      end else begin
        bit m_push, m_pop;
        m_push = in_valid && (mq.size() < 2);
        m_pop  = (mq.size() > 0) && out_ready;
        if (m_push && in_overflow) begin
          m_sticky = 1;
          if (m_count < 255) m_count++;
        end else if (ovf_sticky_clr) begin
          m_sticky = 0;
        end
        if (m_pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (m_push) mq.push_back('{r: in_result, o: in_overflow, rd: in_rd});
        if (mq.size() > 0) held = mq[0];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit ev;
        ev = (mq.size() > 0);
        check("out_valid", out_valid, ev);
        check("in_ready", in_ready, mq.size() < 2);
        check("out_result", out_result, held.r);
        check("out_overflow", out_overflow, held.o);
        check("out_rd", out_rd, held.rd);
        check("out_we", out_we, ev && (held.rd != 0));
        check("ovf_sticky", ovf_sticky, m_sticky);
        check("ovf_count", ovf_count, m_count);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd, input logic o);
    in_valid = v; in_result = r; in_rd = rd; in_overflow = o;
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_result = 0; in_overflow = 0;
    in_rd = 0; out_ready = 0; ovf_sticky_clr = 0;
    cyc(3);
    rst_n = 1;
    chk_en = 1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_count", ovf_count, 0);

    // single op
    drive(1, 32'h5, 5'd3, 0); out_ready = 1;
    cyc(1); in_valid = 0;
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 32'h5);
    check("single_we", out_we, 1);
    cyc(1);
    check("single_drain", out_valid, 0);

    // back-to-back with stall
    out_ready = 0; drive(1, 32'h11, 5'd1, 0);
    cyc(1); in_result = 32'h22;
    cyc(1); in_valid = 0;
    check("stall_ready", in_ready, 0);
    check("stall_first", out_result, 32'h11);
    out_ready = 1;
    cyc(1);
    check("stall_second", out_result, 32'h22);
    check("stall_ready_back", in_ready, 1);
    cyc(1);
    check("stall_drain", out_valid, 0);

    // streaming
    for (int i = 0; i < 16; i++) begin
      drive(1, i, 5'd2, 0);
      cyc(1);
      check("stream_ready", in_ready, 1);
      check("stream_data", out_result, i);
    end
    in_valid = 0;
    cyc(1);
    check("stream_drain", out_valid, 0);

    // x0 suppression
    out_ready = 0; drive(1, 32'hFFFF_FFFF, 5'd0, 0);
    cyc(1); in_valid = 0;
    check("x0_valid", out_valid, 1);
    check("x0_we", out_we, 0);
    out_ready = 1;
    cyc(1);

    // overflow bookkeeping
    drive(1, 32'h8000_0000, 5'd4, 1);
    cyc(1);
    check("ovf_sticky1", ovf_sticky, 1);
    check("ovf_count1", ovf_count, 1);
    ovf_sticky_clr = 1;
    cyc(1); in_valid = 0;
    check("ovf_clr_race", ovf_sticky, 1);
    check("ovf_count2", ovf_count, 2);
    cyc(1); ovf_sticky_clr = 0;
    check("ovf_cleared", ovf_sticky, 0);
    drive(1, 32'h8000_0000, 5'd4, 1);
    cyc(300);
    drive(0, 0, 0, 0);
    cyc(1);
    check("ovf_saturate", ovf_count, 255);

    // flush in FULL
    ovf_sticky_clr = 1; cyc(1); ovf_sticky_clr = 0;
    out_ready = 0; drive(1, 32'hA1, 5'd5, 0);
    cyc(2);
    check("full_ready", in_ready, 0);
    drive(1, 32'hBAD, 5'd6, 0); flush = 1;
    cyc(1); flush = 0; in_valid = 0;
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    // flush with an accepted overflowing push from EMPTY
    drive(1, 32'hDEAD, 5'd7, 1); flush = 1;
    cyc(1); flush = 0; drive(0, 0, 0, 0);
    check("flushpush_valid", out_valid, 0);
    check("flushpush_sticky", ovf_sticky, 1);
    cyc(1);
    check("flushpush_never", out_valid, 0);

    // asynchronous reset mid-stall
    drive(1, 32'hC1, 5'd8, 0);
    cyc(2); in_valid = 0;
    check("prerst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_result", out_result, 0);
    check("arst_count", ovf_count, 0);
    check("arst_sticky", ovf_sticky, 0);
    cyc(1); rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      in_result      = $urandom;
      in_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_overflow    = ($urandom_range(0, 5) == 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 40) == 0);
      ovf_sticky_clr = ($urandom_range(0, 10) == 0);
      cyc(1);
    end
    drive(0, 0, 0, 0); flush = 0; ovf_sticky_clr = 0; out_ready = 1;
    cyc(3);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
